// File: rtl/ctrl_frame_capture.sv
// Captures control-flagged frames from the header/body FIFOs into a circular slot buffer read by the CPU.
// Optional macro CTRL_FRAME_IRQ_EN adds a registered irq output, high while any frame is buffered.
module ctrl_frame_capture #(
  parameter int HEADER_DWIDTH = 128,
  parameter int CTRL_FLAG_BIT = 114,
  parameter int SLOT_LOG2     = 5,
  parameter int WORDS_LOG2    = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
  input  logic                     h_fifo_empty,
  output logic                     h_fifo_rden,
  input  logic [7:0]               b_fifo_dout,
  input  logic                     b_fifo_empty,
  input  logic                     b_fifo_del,
  output logic                     b_fifo_rden,
  input  logic [WORDS_LOG2-1:0]    rd_addr,
  output logic [31:0]              rd_data,
  input  logic                     cfg_we,
  input  logic [31:0]              cfg_di,
  output logic [31:0]              cfg_do
`ifdef CTRL_FRAME_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int SLOTS     = 1 << SLOT_LOG2;
  localparam int CAP_BYTES = ((1 << WORDS_LOG2) - 4) * 4;
  localparam int BCW       = $clog2(CAP_BYTES + 1);
  localparam int PW        = SLOT_LOG2 + 1;
  localparam int AW        = SLOT_LOG2 + WORDS_LOG2;
  localparam logic [47:0] MAC_BPDU  = 48'h0180C2000000;
  localparam logic [47:0] MAC_PAUSE = 48'h0180C2000001;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0]     pack_q, pack_d;
  logic            trunc_q, trunc_d;
  logic            discard_q, discard_d;
  logic            drop_full_q, drop_full_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            ign_bpdu_q, ign_bpdu_d;
  logic            ign_pause_q, ign_pause_d;
  logic            h_rden_q, h_rden_d;
  logic [31:0]     rd_data_q;

  logic [31:0]     frame_mem [2**AW];
  logic [7:0]      len_mem   [SLOTS];
  logic            trunc_mem [SLOTS];

  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [31:0]           mem_wdata;
  logic                  len_we;
  logic [31:0]           hdr_word;
  logic [31:0]           packed_word;
  logic [PW-1:0]         occupancy;
  logic                  buf_empty, buf_full;
  logic [SLOT_LOG2-1:0]  wr_slot, rd_slot;
  logic                  unused_cfg;

  assign wr_slot    = wr_ptr_q[SLOT_LOG2-1:0];
  assign rd_slot    = rd_ptr_q[SLOT_LOG2-1:0];
  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign buf_empty  = (wr_ptr_q == rd_ptr_q);
  assign buf_full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[SLOT_LOG2-1:0] == rd_ptr_q[SLOT_LOG2-1:0]);
  assign unused_cfg = ^{cfg_di[31], cfg_di[27:1]};

  assign h_fifo_rden = h_rden_q;
  assign b_fifo_rden = (state_q == S_BODY) && !b_fifo_empty;
  assign rd_data     = rd_data_q;
  assign len_we      = (state_q == S_COMMIT) && !discard_q;

  always_comb begin
    case (hdr_cnt_q)
      2'd0:    hdr_word = h_fifo_dout[127:96];
      2'd1:    hdr_word = h_fifo_dout[95:64];
      2'd2:    hdr_word = h_fifo_dout[63:32];
      default: hdr_word = h_fifo_dout[31:0];
    endcase
  end

  // Incoming byte lands at its big-endian lane; unfilled low lanes stay zero.
  assign packed_word = pack_q | ({b_fifo_dout, 24'h0} >> {byte_cnt_q[1:0], 3'b000});

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    pack_d      = pack_q;
    trunc_d     = trunc_q;
    discard_d   = discard_q;
    drop_full_d = drop_full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    ign_bpdu_d  = ign_bpdu_q;
    ign_pause_d = ign_pause_q;
    mem_we      = 1'b0;
    mem_addr    = {wr_slot, WORDS_LOG2'(hdr_cnt_q)};
    mem_wdata   = hdr_word;

    case (state_q)
      S_IDLE: begin
        if (!h_fifo_empty && h_fifo_dout[CTRL_FLAG_BIT]) begin
          state_d     = S_HDR;
          hdr_cnt_d   = 2'd0;
          byte_cnt_d  = '0;
          pack_d      = '0;
          trunc_d     = 1'b0;
          drop_full_d = buf_full;
          discard_d   = buf_full ||
                        (ign_bpdu_q  && (h_fifo_dout[111:64] == MAC_BPDU)) ||
                        (ign_pause_q && (h_fifo_dout[111:64] == MAC_PAUSE));
        end
      end
      S_HDR: begin
        mem_we    = !discard_q;
        hdr_cnt_d = hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'd3) state_d = S_BODY;
      end
      S_BODY: begin
        if (b_fifo_rden) begin
          if (byte_cnt_q < BCW'(CAP_BYTES)) begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            if (byte_cnt_q[1:0] == 2'd3 || b_fifo_del) begin
              mem_we    = !discard_q;
              mem_addr  = {wr_slot, WORDS_LOG2'(byte_cnt_q >> 2) + WORDS_LOG2'(4)};
              mem_wdata = packed_word;
              pack_d    = '0;
            end else begin
              pack_d = packed_word;
            end
          end else begin
            trunc_d = 1'b1;
          end
          if (b_fifo_del) state_d = S_COMMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (!discard_q) wr_ptr_d = wr_ptr_q + PW'(1);
        else if (drop_full_q && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    endcase

    if (cfg_we) begin
      ign_bpdu_d  = cfg_di[29];
      ign_pause_d = cfg_di[28];
      if (cfg_di[30] && !buf_empty) rd_ptr_d = rd_ptr_q + PW'(1);
      if (cfg_di[0] && !cfg_di[30]) drop_cnt_d = 8'h00;
    end

    h_rden_d = (state_d == S_COMMIT);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      hdr_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      pack_q      <= '0;
      trunc_q     <= 1'b0;
      discard_q   <= 1'b0;
      drop_full_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      ign_bpdu_q  <= 1'b0;
      ign_pause_q <= 1'b0;
      h_rden_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      pack_q      <= pack_d;
      trunc_q     <= trunc_d;
      discard_q   <= discard_d;
      drop_full_q <= drop_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      ign_bpdu_q  <= ign_bpdu_d;
      ign_pause_q <= ign_pause_d;
      h_rden_q    <= h_rden_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) frame_mem[mem_addr] <= mem_wdata;
    if (len_we) begin
      len_mem[wr_slot]   <= 8'(byte_cnt_q);
      trunc_mem[wr_slot] <= trunc_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rd_data_q <= '0;
    else         rd_data_q <= frame_mem[{rd_slot, rd_addr}];
  end

  // Per-slot metadata is meaningless when nothing is buffered, so it reads as zero then.
  assign cfg_do = {!buf_empty, 1'b0, ign_bpdu_q, ign_pause_q,
                   !buf_empty && trunc_mem[rd_slot], 3'b000,
                   drop_cnt_q, 8'(occupancy),
                   buf_empty ? 8'h00 : len_mem[rd_slot]};

`ifdef CTRL_FRAME_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) irq_q <= 1'b0;
    else         irq_q <= !(wr_ptr_d == rd_ptr_d);
  end
  assign irq = irq_q;
`endif

endmodule
